// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared encodings for the multi-cycle RV32I-subset sequencer: major opcodes,
// ALU operation codes, sequencer states and the PC / write-back select codes
// driven into the datapath.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

  // Major opcodes (instr[6:0]) accepted by the sequencer
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // funct7 values that are meaningful for OP / shift-immediate forms
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;  // PC + 4
  localparam logic [1:0] PC_SRC_TARGET = 2'd1;  // OLDPC + imm

  // Register-file write-back select
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;  // OLDPC + 4
  localparam logic [1:0] WB_IMM  = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Shared instruction/data memory port. The sequencer is the master: it raises
// mem_req (with addr_sel / mem_we stable) and holds it until mem_ready.
//   mem_req   : request pending
//   mem_we    : store qualifier
//   addr_sel  : 0 = PC, 1 = ALU result
//   mem_rdata : read data (instruction source during fetch)
//   mem_ready : transfer completes on the edge where this is sampled high
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
// Combinational instruction classifier: maps opcode/funct3/funct7 to the ALU
// operation and flags encodings outside the supported subset. Used for the
// legality decision in DECODE and the ALU controls in EXEC/MEM.
//   i_opcode, i_funct3, i_funct7 : fields of the latched instruction
//   o_alu_op                     : ALU operation
//   o_illegal                    : instruction not in the supported subset
// ---------------------------------------------------------------------------
module alu_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output alu_op_e    o_alu_op,
  output logic       o_illegal
);

  // Common funct3 -> ALU mapping for the OP and OP-IMM groups
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;  // 3'b011 (unsigned compare) is not supported
    endcase
    return op;
  endfunction

  // Classify the instruction and select the ALU operation
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_OP_IMM: begin
        o_alu_op = f3_to_alu(i_funct3);
        // funct7 is immediate data except for the shift forms
        if (i_funct3 == 3'b011) begin
          o_illegal = 1'b1;
        end else if (((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) && (i_funct7 != F7_BASE)) begin
          o_illegal = 1'b1;
        end else begin
          o_illegal = 1'b0;
        end
      end
      OPC_OP: begin
        if (i_funct7 == F7_BASE) begin
          o_alu_op  = f3_to_alu(i_funct3);
          o_illegal = (i_funct3 == 3'b011);
        end else if ((i_funct7 == F7_ALT) && (i_funct3 == 3'b000)) begin
          o_alu_op  = ALU_SUB;
          o_illegal = 1'b0;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        o_alu_op  = ALU_ADD;
        o_illegal = (i_funct3 != 3'b010);  // word access only
      end
      OPC_BRANCH: begin
        o_alu_op  = ALU_SUB;
        o_illegal = (i_funct3[2:1] != 2'b00);  // beq / bne only
      end
      OPC_JAL, OPC_LUI: begin
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
      end
      default: begin
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencer for the RV32I-subset datapath. Fetches over the shared
// memory port, latches the instruction, and drives per-cycle strobes/selects.
//   clk, reset    : clock, synchronous active-high reset
//   mem_if        : shared memory port (master side)
//   i_alu_zero    : ALU result == 0 (branch condition)
//   o_ir_we       : datapath IR/OLDPC capture
//   o_pc_we       : PC write, o_pc_src selects PC+4 or OLDPC+imm
//   o_rf_we       : register file write, o_wb_sel selects the source
//   o_alu_op      : ALU operation, o_alu_src_b = 1 selects the immediate
//   o_trap        : illegal instruction seen (held until reset)
//   o_state       : current state, for debug
// Outputs are combinational from state, latched IR and the handshake inputs.
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR = 32'h00000013
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   mem_if,
  input  logic                i_alu_zero,
  output logic                o_ir_we,
  output logic                o_pc_we,
  output logic [1:0]          o_pc_src,
  output logic                o_rf_we,
  output logic [1:0]          o_wb_sel,
  output logic [2:0]          o_alu_op,
  output logic                o_alu_src_b,
  output logic                o_trap,
  output logic [2:0]          o_state
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_ir;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  alu_op_e     w_dec_alu_op;
  logic        w_illegal;
  logic        w_ir_unused;

  logic        w_is_op;
  logic        w_is_op_imm;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_is_jal;
  logic        w_is_lui;
  logic        w_uses_imm;

  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_addr_sel;
  logic        w_ir_we;
  logic        w_pc_we;
  logic [1:0]  w_pc_src;
  logic        w_rf_we;
  logic [1:0]  w_wb_sel;
  alu_op_e     w_alu_op;
  logic        w_alu_src_b;
  logic        w_trap;

  assign w_opcode = r_ir[6:0];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];
  // Register and immediate fields are consumed by the datapath's own IR copy
  assign w_ir_unused = ^{r_ir[24:15], r_ir[11:7]};

  assign w_is_op     = (w_opcode == OPC_OP);
  assign w_is_op_imm = (w_opcode == OPC_OP_IMM);
  assign w_is_load   = (w_opcode == OPC_LOAD);
  assign w_is_store  = (w_opcode == OPC_STORE);
  assign w_is_branch = (w_opcode == OPC_BRANCH);
  assign w_is_jal    = (w_opcode == OPC_JAL);
  assign w_is_lui    = (w_opcode == OPC_LUI);
  assign w_uses_imm  = w_is_op_imm | w_is_load | w_is_store;

  alu_decode u_alu_decode (
    .i_opcode  (w_opcode),
    .i_funct3  (w_funct3),
    .i_funct7  (w_funct7),
    .o_alu_op  (w_dec_alu_op),
    .o_illegal (w_illegal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction latch, loaded on the completing fetch beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= RESET_IR;
    end else if (w_ir_we) begin
      r_ir <= mem_if.mem_rdata;
    end
  end

  // Next-state and per-cycle control outputs
  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_addr_sel   = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = PC_SRC_SEQ;
    w_rf_we      = 1'b0;
    w_wb_sel     = WB_ALU;
    w_alu_op     = ALU_ADD;
    w_alu_src_b  = 1'b0;
    w_trap       = 1'b0;
    if (reset) begin
      // Any pending request is abandoned; nothing fires this cycle
      w_next_state = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_mem_req  = 1'b1;
          w_addr_sel = 1'b0;
          if (mem_if.mem_ready) begin
            w_ir_we      = 1'b1;
            w_pc_we      = 1'b1;
            w_pc_src     = PC_SRC_SEQ;
            w_next_state = ST_DECODE;
          end else begin
            w_next_state = ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (w_illegal) begin
            w_next_state = ST_TRAP;
          end else if (w_is_lui) begin
            w_next_state = ST_WB;
          end else begin
            w_next_state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          w_alu_op    = w_dec_alu_op;
          w_alu_src_b = w_uses_imm;
          if (w_is_op || w_is_op_imm) begin
            w_next_state = ST_WB;
          end else if (w_is_load || w_is_store) begin
            w_next_state = ST_MEM;
          end else if (w_is_branch) begin
            // funct3[0] distinguishes bne from beq
            w_pc_we      = w_funct3[0] ? ~i_alu_zero : i_alu_zero;
            w_pc_src     = PC_SRC_TARGET;
            w_next_state = ST_FETCH;
          end else if (w_is_jal) begin
            w_rf_we      = 1'b1;
            w_wb_sel     = WB_LINK;
            w_pc_we      = 1'b1;
            w_pc_src     = PC_SRC_TARGET;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_TRAP;
          end
        end
        ST_MEM: begin
          // ALU keeps producing the address while the request is pending
          w_mem_req   = 1'b1;
          w_addr_sel  = 1'b1;
          w_mem_we    = w_is_store;
          w_alu_op    = w_dec_alu_op;
          w_alu_src_b = w_uses_imm;
          if (mem_if.mem_ready) begin
            w_next_state = w_is_store ? ST_FETCH : ST_WB;
          end else begin
            w_next_state = ST_MEM;
          end
        end
        ST_WB: begin
          w_rf_we = 1'b1;
          if (w_is_load) begin
            w_wb_sel = WB_MEM;
          end else if (w_is_lui) begin
            w_wb_sel = WB_IMM;
          end else begin
            w_wb_sel = WB_ALU;
          end
          w_next_state = ST_FETCH;
        end
        ST_TRAP: begin
          w_trap       = 1'b1;
          w_next_state = ST_TRAP;
        end
        default: begin
          // Unreachable encoding: park safely until reset
          w_next_state = ST_TRAP;
        end
      endcase
    end
  end

  assign mem_if.mem_req  = w_mem_req;
  assign mem_if.mem_we   = w_mem_we;
  assign mem_if.addr_sel = w_addr_sel;
  assign o_ir_we         = w_ir_we;
  assign o_pc_we         = w_pc_we;
  assign o_pc_src        = w_pc_src;
  assign o_rf_we         = w_rf_we;
  assign o_wb_sel        = w_wb_sel;
  assign o_alu_op        = w_alu_op;
  assign o_alu_src_b     = w_alu_src_b;
  assign o_trap          = w_trap;
  assign o_state         = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench: instructions are assembled from a mnemonic table,
// their cycle-by-cycle control response is derived from the instruction
// class and pushed into a scoreboard; a monitor compares every cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b1;
  logic reset;
  logic alu_zero;
  logic ir_we, pc_we, rf_we, alu_src_b, trap;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] alu_op, state;

  // negedge at 5, posedge at 10, ...
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RESET_IR(32'h00000013)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_if      (bus),
    .i_alu_zero  (alu_zero),
    .o_ir_we     (ir_we),
    .o_pc_we     (pc_we),
    .o_pc_src    (pc_src),
    .o_rf_we     (rf_we),
    .o_wb_sel    (wb_sel),
    .o_alu_op    (alu_op),
    .o_alu_src_b (alu_src_b),
    .o_trap      (trap),
    .o_state     (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       trap;
    logic       req;
    logic       we;
    logic       asel;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic       rfwe;
    logic [1:0] wbsel;
    logic [2:0] aop;
    logic       srcb;
  } obs_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        zero;
  } stim_t;

  typedef struct {
    obs_t exp;
    obs_t mask;
    int   tag;
  } chk_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f3fix;
    logic [6:0] f7;
    logic       f7fix;
    int         kind;
    logic [2:0] aop;
  } ent_t;

  localparam int K_OPIMM = 0, K_OP = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                 K_BNE = 5, K_JAL = 6, K_LUI = 7, K_ILL = 8;

  stim_t stim_q[$];
  chk_t  chk_q[$];
  ent_t  tbl[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic obs_t strobe_mask();
    obs_t m = '0;
    m.st = 3'b111; m.trap = 1'b1; m.req = 1'b1; m.we = 1'b1;
    m.irwe = 1'b1; m.pcwe = 1'b1; m.rfwe = 1'b1;
    return m;
  endfunction

  task automatic add(input logic [6:0] opc, input logic [2:0] f3, input logic f3fix,
                     input logic [6:0] f7, input logic f7fix, input int kind, input logic [2:0] aop);
    ent_t e;
    e.opc = opc; e.f3 = f3; e.f3fix = f3fix; e.f7 = f7; e.f7fix = f7fix; e.kind = kind; e.aop = aop;
    tbl.push_back(e);
  endtask

  task automatic init_table();
    // OP-IMM: addi slti xori ori andi slli srli
    add(7'b0010011, 3'b000, 1'b1, 7'h00, 1'b0, K_OPIMM, 3'd0);
    add(7'b0010011, 3'b010, 1'b1, 7'h00, 1'b0, K_OPIMM, 3'd5);
    add(7'b0010011, 3'b100, 1'b1, 7'h00, 1'b0, K_OPIMM, 3'd4);
    add(7'b0010011, 3'b110, 1'b1, 7'h00, 1'b0, K_OPIMM, 3'd3);
    add(7'b0010011, 3'b111, 1'b1, 7'h00, 1'b0, K_OPIMM, 3'd2);
    add(7'b0010011, 3'b001, 1'b1, 7'h00, 1'b1, K_OPIMM, 3'd6);
    add(7'b0010011, 3'b101, 1'b1, 7'h00, 1'b1, K_OPIMM, 3'd7);
    // OP: add sub sll slt xor srl or and
    add(7'b0110011, 3'b000, 1'b1, 7'h00, 1'b1, K_OP, 3'd0);
    add(7'b0110011, 3'b000, 1'b1, 7'h20, 1'b1, K_OP, 3'd1);
    add(7'b0110011, 3'b001, 1'b1, 7'h00, 1'b1, K_OP, 3'd6);
    add(7'b0110011, 3'b010, 1'b1, 7'h00, 1'b1, K_OP, 3'd5);
    add(7'b0110011, 3'b100, 1'b1, 7'h00, 1'b1, K_OP, 3'd4);
    add(7'b0110011, 3'b101, 1'b1, 7'h00, 1'b1, K_OP, 3'd7);
    add(7'b0110011, 3'b110, 1'b1, 7'h00, 1'b1, K_OP, 3'd3);
    add(7'b0110011, 3'b111, 1'b1, 7'h00, 1'b1, K_OP, 3'd2);
    // lw sw beq bne jal lui
    add(7'b0000011, 3'b010, 1'b1, 7'h00, 1'b0, K_LW, 3'd0);
    add(7'b0100011, 3'b010, 1'b1, 7'h00, 1'b0, K_SW, 3'd0);
    add(7'b1100011, 3'b000, 1'b1, 7'h00, 1'b0, K_BEQ, 3'd1);
    add(7'b1100011, 3'b001, 1'b1, 7'h00, 1'b0, K_BNE, 3'd1);
    add(7'b1101111, 3'b000, 1'b0, 7'h00, 1'b0, K_JAL, 3'd0);
    add(7'b0110111, 3'b000, 1'b0, 7'h00, 1'b0, K_LUI, 3'd0);
    // illegal: sltiu srai mul and-alt sltu lh sb blt auipc system custom
    add(7'b0010011, 3'b011, 1'b1, 7'h00, 1'b0, K_ILL, 3'd0);
    add(7'b0010011, 3'b101, 1'b1, 7'h20, 1'b1, K_ILL, 3'd0);
    add(7'b0110011, 3'b000, 1'b1, 7'h01, 1'b1, K_ILL, 3'd0);
    add(7'b0110011, 3'b111, 1'b1, 7'h20, 1'b1, K_ILL, 3'd0);
    add(7'b0110011, 3'b011, 1'b1, 7'h00, 1'b1, K_ILL, 3'd0);
    add(7'b0000011, 3'b001, 1'b1, 7'h00, 1'b0, K_ILL, 3'd0);
    add(7'b0100011, 3'b000, 1'b1, 7'h00, 1'b0, K_ILL, 3'd0);
    add(7'b1100011, 3'b100, 1'b1, 7'h00, 1'b0, K_ILL, 3'd0);
    add(7'b0010111, 3'b000, 1'b0, 7'h00, 1'b0, K_ILL, 3'd0);
    add(7'b1110011, 3'b000, 1'b0, 7'h00, 1'b0, K_ILL, 3'd0);
    add(7'b1111111, 3'b000, 1'b0, 7'h00, 1'b0, K_ILL, 3'd0);
  endtask

  // One clock cycle: stimulus for the driver, expectation for the monitor.
  // Selects are only compared when the strobe that uses them is expected.
  task automatic cyc(input logic rst, input logic rdy, input logic [31:0] rd, input logic zero,
                     input obs_t e, input obs_t m, input int tag);
    stim_t s;
    chk_t  c;
    obs_t  mm;
    s.rst = rst; s.rdy = rdy; s.rdata = rd; s.zero = zero;
    stim_q.push_back(s);
    mm = m;
    if (!rst) begin
      if (e.req)  mm.asel  = 1'b1;
      if (e.pcwe) mm.pcsrc = 2'b11;
      if (e.rfwe) mm.wbsel = 2'b11;
    end
    c.exp = e; c.mask = mm; c.tag = tag;
    chk_q.push_back(c);
  endtask

  // Reset cycle: every strobe and select must be 0; state and trap still show the old value
  task automatic reset_cycle(input int tag);
    obs_t e = '0;
    obs_t m = '1;
    m.st = 3'b000; m.trap = 1'b0;
    cyc(1'b1, rbit(), $urandom, rbit(), e, m, tag);
  endtask

  task automatic run(input logic [31:0] instr, input int kind, input logic [2:0] aop,
                     input int fw, input int mw, input logic zero, input int trapn,
                     input logic abort, input int tag);
    obs_t e;
    obs_t m;
    obs_t ma;
    m  = strobe_mask();
    ma = m; ma.aop = 3'b111; ma.srcb = 1'b1;
    // fetch: wait states, then the completing beat
    for (int i = 0; i < fw; i++) begin
      e = '0; e.req = 1'b1;
      cyc(1'b0, 1'b0, $urandom, rbit(), e, m, tag);
    end
    e = '0; e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1; e.pcsrc = PC_SRC_SEQ;
    cyc(1'b0, 1'b1, instr, rbit(), e, m, tag);
    // decode: mem_ready is noise here and must be ignored
    e = '0; e.st = 3'd1;
    cyc(1'b0, rbit(), $urandom, rbit(), e, m, tag);
    if (kind == K_ILL) begin
      for (int i = 0; i < trapn; i++) begin
        e = '0; e.st = 3'd5; e.trap = 1'b1;
        cyc(1'b0, rbit(), $urandom, rbit(), e, m, tag);
      end
      reset_cycle(tag);
    end else if (kind == K_LUI) begin
      e = '0; e.st = 3'd4; e.rfwe = 1'b1; e.wbsel = WB_IMM;
      cyc(1'b0, rbit(), $urandom, rbit(), e, m, tag);
    end else begin
      e = '0; e.st = 3'd2;
      case (kind)
        K_OPIMM, K_OP, K_LW, K_SW: begin
          e.aop  = aop;
          e.srcb = (kind != K_OP);
          cyc(1'b0, rbit(), $urandom, rbit(), e, ma, tag);
        end
        K_BEQ, K_BNE: begin
          e.aop   = aop;
          e.srcb  = 1'b0;
          e.pcwe  = (kind == K_BEQ) ? zero : ~zero;
          e.pcsrc = PC_SRC_TARGET;
          cyc(1'b0, rbit(), $urandom, zero, e, ma, tag);
        end
        K_JAL: begin
          e.rfwe = 1'b1; e.wbsel = WB_LINK; e.pcwe = 1'b1; e.pcsrc = PC_SRC_TARGET;
          cyc(1'b0, rbit(), $urandom, rbit(), e, m, tag);
        end
        default: begin
          e.trap = 1'b1;  // unknown class in the table: force a visible miscompare
          cyc(1'b0, 1'b0, $urandom, 1'b0, e, m, tag);
        end
      endcase
      if (kind == K_OP || kind == K_OPIMM) begin
        e = '0; e.st = 3'd4; e.rfwe = 1'b1; e.wbsel = WB_ALU;
        cyc(1'b0, rbit(), $urandom, rbit(), e, m, tag);
      end else if (kind == K_LW || kind == K_SW) begin
        e = '0; e.st = 3'd3; e.req = 1'b1; e.asel = 1'b1; e.we = (kind == K_SW);
        e.aop = 3'd0; e.srcb = 1'b1;
        for (int i = 0; i < mw; i++) begin
          cyc(1'b0, 1'b0, $urandom, rbit(), e, ma, tag);
        end
        if (abort) begin
          reset_cycle(tag);
        end else begin
          cyc(1'b0, 1'b1, $urandom, rbit(), e, ma, tag);
          if (kind == K_LW) begin
            e = '0; e.st = 3'd4; e.rfwe = 1'b1; e.wbsel = WB_MEM;
            cyc(1'b0, rbit(), $urandom, rbit(), e, m, tag);
          end
        end
      end
    end
  endtask

  task automatic build();
    ent_t        en;
    logic [31:0] ins;
    int          idx;
    init_table();
    reset_cycle(0);
    reset_cycle(0);
    run(32'h00500093, K_OPIMM, 3'd0, 0, 0, 1'b0, 0, 1'b0, 1);  // addi x1,x0,5
    run(32'h0040A103, K_LW,    3'd0, 0, 2, 1'b0, 0, 1'b0, 2);  // lw, 2 stall cycles
    run(32'h00000463, K_BEQ,   3'd1, 0, 0, 1'b1, 0, 1'b0, 3);  // beq taken
    run(32'h00000463, K_BEQ,   3'd1, 0, 0, 1'b0, 0, 1'b0, 4);  // beq not taken
    run(32'h402081B3, K_OP,    3'd1, 0, 0, 1'b0, 0, 1'b0, 5);  // sub
    run(32'h0020A223, K_SW,    3'd0, 0, 0, 1'b0, 0, 1'b0, 6);  // sw
    run(32'hFFFFFFFF, K_ILL,   3'd0, 0, 0, 1'b0, 20, 1'b0, 7); // trap, then reset
    run(32'h0040A103, K_LW,    3'd0, 0, 2, 1'b0, 0, 1'b1, 8);  // reset during MEM stall
    run(32'h00500093, K_OPIMM, 3'd0, 1, 0, 1'b0, 0, 1'b0, 9);  // fetch after abort
    for (int i = 0; i < 160; i++) begin
      idx = $urandom_range(0, tbl.size() - 1);
      en  = tbl[idx];
      ins = $urandom;
      ins[6:0] = en.opc;
      if (en.f3fix) ins[14:12] = en.f3;
      if (en.f7fix) ins[31:25] = en.f7;
      run(ins, en.kind, en.aop, $urandom_range(0, 2), $urandom_range(0, 3), rbit(),
          $urandom_range(1, 4), ($urandom_range(0, 7) == 0), 100 + i);
    end
  endtask

  task automatic apply(input stim_t s);
    reset         = s.rst;
    bus.mem_ready = s.rdy;
    bus.mem_rdata = s.rdata;
    alu_zero      = s.zero;
  endtask

  task automatic driver();
    apply(stim_q.pop_front());
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      apply(stim_q.pop_front());
    end
  endtask

  task automatic monitor();
    chk_t c;
    obs_t act;
    int   n = 0;
    while (chk_q.size() > 0) begin
      @(negedge clk);
      c   = chk_q.pop_front();
      act = {state, trap, bus.mem_req, bus.mem_we, bus.addr_sel, ir_we, pc_we,
             pc_src, rf_we, wb_sel, alu_op, alu_src_b};
      checks++;
      if ((act & c.mask) !== (c.exp & c.mask)) begin
        errors++;
        $display("FAIL cycle %0d tag %0d ctrl_outputs got %h expected %h (mask %h)",
                 n, c.tag, act, c.exp, c.mask);
      end
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    build();
    fork
      driver();
      monitor();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I-subset core datapath.
- Fetches each instruction over a shared req/ready memory port and latches it internally.
- Decodes the instruction and drives per-cycle strobes and selects for PC, IR, register file, ALU, memory and write-back.
- Lets one memory port serve both instruction and data traffic. Sits between the memory interface and the existing datapath.

Parameters:
- RESET_IR, 32'h00000013, IR contents after reset (NOP).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- mem_rdata  in  32  memory read data; instruction source in FETCH.
- mem_ready  in  1  memory handshake completion.
- alu_zero  in  1  ALU result == 0.
- mem_req  out  1  memory request.
- mem_we  out  1  store request qualifier.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  datapath IR/OLDPC capture strobe.
- pc_we  out  1  PC write strobe.
- pc_src  out  2  0 = PC+4, 1 = OLDPC+imm (branch/jal).
- rf_we  out  1  register file write.
- wb_sel  out  2  0 = ALU, 1 = MEM, 2 = OLDPC+4, 3 = IMM (lui).
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL.
- alu_src_b  out  1  0 = rs2, 1 = imm.
- trap  out  1  illegal instruction, sticky.
- state  out  3  debug state encoding.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset: state=FETCH, IR=RESET_IR, trap=0. All strobes (mem_req, mem_we, ir_we, pc_we, rf_we) are forced 0 while reset is high. Selects are 0.
- Strobes are combinational from state, latched IR and mem_ready/alu_zero. No extra output latency.
- Memory handshake:
  - mem_req holds high, with addr_sel and mem_we stable, until mem_ready is sampled high.
  - The transfer completes on that edge.
  - mem_ready while mem_req=0 is ignored.
- FETCH: mem_req=1, addr_sel=0. When mem_ready=1: ir_we=1, pc_we=1 (pc_src=0), IR<=mem_rdata, go to DECODE. Otherwise stay in FETCH.
- DECODE: always 1 cycle.
  - Illegal opcode/funct -> TRAP.
  - LUI -> WB.
  - All others -> EXEC.
- Supported instructions:
  - OP-IMM: addi, andi, ori, xori, slti, slli, srli.
  - OP: add, sub, and, or, xor, slt, sll, srl.
  - lw, sw, beq, bne, jal, lui.
  - Anything else is illegal, including funct7 ≠ 0 except sub.
- EXEC:
  - OP/OP-IMM: alu_op from funct3/funct7; alu_src_b = 1 for OP-IMM. Next state WB.
  - LW/SW: alu_op=ADD, alu_src_b=1. Next state MEM.
  - BEQ/BNE: alu_op=SUB, alu_src_b=0. pc_we = alu_zero (beq) or !alu_zero (bne), with pc_src=1. Next state FETCH.
  - JAL: rf_we=1, wb_sel=2, pc_we=1, pc_src=1. Next state FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for sw. Hold ALU controls from EXEC. On mem_ready: sw -> FETCH, lw -> WB. Otherwise stay.
- WB: rf_we=1 for exactly one cycle; wb_sel = 1 for lw, 3 for lui, 0 otherwise. Next state FETCH.
- TRAP: trap=1, all strobes 0, stays until reset.
- Cycle counts with mem_ready=1 immediately:
  - OP/OP-IMM: 4.
  - lw: 5.
  - sw: 4.
  - branch, jal, lui: 3.
- Reset mid-operation (any state, including a pending memory wait): the next cycle is FETCH. The outstanding request is abandoned and no strobe fires in the reset cycle.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, LUI);
  - the alu_op encodings;
  - the state enum;
  - the pc_src and wb_sel codes.
- Sub-module alu_decode: combinational funct3/funct7/opcode -> alu_op plus an illegal flag. It is reused by EXEC and DECODE.

Test Plan:
- Reset, mem_ready=1, mem_rdata=0x00500093 (addi x1,x0,5):
  - cycle 0: mem_req=1, ir_we=1, pc_we=1;
  - cycle 1: DECODE;
  - cycle 2: EXEC with alu_op=0, alu_src_b=1;
  - cycle 3: rf_we=1, wb_sel=0;
  - cycle 4: back in FETCH.
- 0x0040A103 (lw x2,4(x1)) with mem_ready held low 2 cycles in MEM:
  - mem_req=1 and addr_sel=1 for 3 cycles;
  - then one WB cycle with rf_we=1, wb_sel=1.
- 0x00000463 (beq x0,x0,8):
  - alu_zero=1 -> EXEC pc_we=1, pc_src=1, alu_op=1;
  - rerun with alu_zero=0 -> pc_we=0;
  - rf_we never asserts.
- 0x402081B3 (sub x3,x1,x2) -> EXEC alu_op=1, alu_src_b=0. sw 0x0020A223 -> MEM with mem_we=1 and no rf_we.
- 0xFFFFFFFF -> DECODE then TRAP. trap=1, no mem_req for 20 cycles; reset clears trap and restarts FETCH.
- Reset asserted during a stalled MEM wait:
  - mem_req=0 in the reset cycle;
  - the cycle after reset deasserts is FETCH with addr_sel=0.
